// File: rtl/mod_count_pkg.sv
// rtl/mod_count_pkg.sv - shared count width, FSM encoding and default modulus for the mod counter slice
package mod_count_pkg;

    localparam int COUNT_W     = 3;
    localparam int RUN_W       = 3;
    localparam int DEFAULT_MOD = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    // Successor of cur in the modulo sequence; values past MOD-1 simply increment in COUNT_W bits.
    function automatic logic [COUNT_W-1:0] next_count(input logic [COUNT_W-1:0] cur, input int modulus);
        return (cur == COUNT_W'(modulus - 1)) ? '0 : cur + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/mod_count_checker_sat_counter.sv
// rtl/mod_count_checker_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mod_count_checker.sv
// rtl/mod_count_checker.sv - sequence checker for a modulo counter stream; MOD_COUNT_CHECK_HOLD_EN treats repeats as legal holds
module mod_count_checker
    import mod_count_pkg::*;
#(
    parameter int MOD      = DEFAULT_MOD,
    parameter int LOCK_CNT = 2,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               clr,
    output logic               lock,
    output logic               wrap_pulse,
    output logic [WRAP_W-1:0]  wrap_count,
    output logic               err_pulse,
    output logic               err_sticky,
    output logic [ERR_W-1:0]   err_count
);

    localparam logic [COUNT_W-1:0] LAST   = COUNT_W'(MOD - 1);
    localparam logic [COUNT_W:0]   MOD_X  = (COUNT_W + 1)'(MOD);
    localparam logic [RUN_W-1:0]   LOCK_V = RUN_W'(LOCK_CNT);

    state_t             state;
    state_t             state_nxt;
    logic [COUNT_W-1:0] prev;
    logic [COUNT_W-1:0] nxt;
    logic [RUN_W-1:0]   good_run;
    logic [RUN_W-1:0]   good_run_nxt;
    logic               legal;
    logic               good;
    logic               hold;
    logic               wrap_evt;
    logic               err_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        nxt          = next_count(prev, MOD);
        legal        = ({1'b0, count_in} < MOD_X);
        good         = legal && (count_in == nxt);
`ifdef MOD_COUNT_CHECK_HOLD_EN
        hold         = legal && (count_in == prev);
`else
        hold         = 1'b0;
`endif
        state_nxt    = state;
        good_run_nxt = good_run;
        wrap_evt     = 1'b0;
        err_evt      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt    = SYNC;
                good_run_nxt = '0;
            end
            SYNC: begin
                if (!hold) begin
                    if (good) begin
                        good_run_nxt = good_run + RUN_W'(1);
                        if (good_run_nxt == LOCK_V) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_run_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (!hold) begin
                    if (good) begin
                        // A good step out of MOD-1 can only land on 0, so this is the wrap.
                        wrap_evt = (prev == LAST);
                    end else begin
                        err_evt      = 1'b1;
                        good_run_nxt = '0;
                        state_nxt    = SYNC;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                good_run_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            good_run   <= '0;
            lock       <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            prev       <= count_in;
            good_run   <= good_run_nxt;
            lock       <= (state_nxt == LOCKED);
            wrap_pulse <= wrap_evt;
            err_pulse  <= err_evt;
            if (clr) begin
                err_sticky <= 1'b0;
            end else if (err_evt) begin
                err_sticky <= 1'b1;
            end
        end
    end

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (wrap_evt),
        .count (wrap_count)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (err_evt),
        .count (err_count)
    );

endmodule

// File: tb/tb_mod_count_checker.sv
// tb/tb_mod_count_checker.sv - randomized and directed bench for mod_count_checker against a behavioural model
module tb_mod_count_checker;

    localparam int MOD      = 6;
    localparam int LOCK_CNT = 2;
    localparam int WRAP_W   = 2;
    localparam int ERR_W    = 4;
    localparam int WMAX     = (1 << WRAP_W) - 1;
    localparam int EMAX     = (1 << ERR_W) - 1;
`ifdef MOD_COUNT_CHECK_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic [2:0]        count_in = '0;
    logic              lock;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              err_pulse;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_count;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: phase 0 = just reset, 1 = hunting for a run, 2 = locked.
    int m_phase  = 0;
    int m_prev   = 0;
    int m_streak = 0;
    bit m_valid  = 1'b0;
    int e_lock = 0, e_wp = 0, e_ep = 0, e_wc = 0, e_ec = 0, e_st = 0;

    mod_count_checker #(
        .MOD      (MOD),
        .LOCK_CNT (LOCK_CNT),
        .WRAP_W   (WRAP_W),
        .ERR_W    (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .clr        (clr),
        .lock       (lock),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input int v);
        int  succ;
        bit  legal, good, hold;
        e_wp = 0;
        e_ep = 0;
        if (r) begin
            m_phase = 0; m_prev = 0; m_streak = 0;
            e_lock = 0; e_wc = 0; e_ec = 0; e_st = 0;
        end else begin
            legal = (v < MOD);
            succ  = (m_prev == MOD - 1) ? 0 : (m_prev + 1) % 8;
            good  = legal && (v == succ);
            hold  = HOLD && legal && (v == m_prev);
            if (m_phase == 0) begin
                m_phase  = 1;
                m_streak = 0;
            end else if (!hold) begin
                if (good && m_phase == 1) begin
                    m_streak++;
                    if (m_streak == LOCK_CNT) m_phase = 2;
                end else if (good) begin
                    e_wp = (m_prev == MOD - 1) ? 1 : 0;
                end else begin
                    e_ep     = (m_phase == 2) ? 1 : 0;
                    m_phase  = 1;
                    m_streak = 0;
                end
            end
            m_prev = v;
            if (c) begin
                e_wc = 0; e_ec = 0; e_st = 0;
            end else begin
                if (e_wp == 1 && e_wc < WMAX) e_wc++;
                if (e_ep == 1) begin
                    if (e_ec < EMAX) e_ec++;
                    e_st = 1;
                end
            end
            e_lock = (m_phase == 2) ? 1 : 0;
        end
        m_valid = 1'b1;
    endtask

    task automatic cycle(input bit r, input bit c, input int v);
        @(negedge clk);
        rst      = r;
        clr      = c;
        count_in = 3'(v);
        @(posedge clk);
        model_step(r, c, v);
    endtask

    task automatic feed(input int v);
        cycle(1'b0, 1'b0, v);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_lock",       int'(lock),       e_lock);
            chk("cmp_wrap_pulse", int'(wrap_pulse), e_wp);
            chk("cmp_err_pulse",  int'(err_pulse),  e_ep);
            chk("cmp_wrap_count", int'(wrap_count), e_wc);
            chk("cmp_err_count",  int'(err_count),  e_ec);
            chk("cmp_err_sticky", int'(err_sticky), e_st);
        end
    end

    int u, p, g;
    bit rr, cc;

    initial begin
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        #1;
        chk("rst_lock", int'(lock), 0);
        chk("rst_wrap_count", int'(wrap_count), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_err_sticky", int'(err_sticky), 0);

        feed(0); feed(1); feed(2);
        #1;
        chk("lockup_lock", int'(lock), 1);
        chk("lockup_model_lock", e_lock, 1);
        chk("lockup_err_pulse", int'(err_pulse), 0);
        feed(3);
        #1;
        chk("lockup_err_count", int'(err_count), 0);

        feed(4); feed(5); feed(0);
        #1;
        chk("wrap_pulse_hi", int'(wrap_pulse), 1);
        chk("wrap_count_1", int'(wrap_count), 1);
        feed(1);
        #1;
        chk("wrap_pulse_lo", int'(wrap_pulse), 0);
        chk("wrap_lock_kept", int'(lock), 1);

        feed(3);
        #1;
        chk("err_pulse_hi", int'(err_pulse), 1);
        chk("err_count_1", int'(err_count), 1);
        chk("err_sticky_1", int'(err_sticky), 1);
        chk("err_lock_drop", int'(lock), 0);
        feed(4); feed(5);
        #1;
        chk("relock_lock", int'(lock), 1);
        chk("relock_sticky", int'(err_sticky), 1);

        feed(7);
        #1;
        chk("illegal_err_pulse", int'(err_pulse), 1);
        chk("illegal_err_count", int'(err_count), 2);
        feed(1); feed(2); feed(7);
        #1;
        chk("sync_illegal_no_pulse", int'(err_pulse), 0);
        chk("sync_illegal_count", int'(err_count), 2);
        feed(0); feed(1);
        #1;
        chk("illegal_relock", int'(lock), 1);

        for (int k = 0; k < 5; k++) begin
            feed(2); feed(3); feed(4); feed(5); feed(0);
        end
        #1;
        chk("wrap_saturated", int'(wrap_count), 3);
        chk("wrap_model_saturated", e_wc, 3);
        feed(1); feed(2); feed(3); feed(4); feed(5);
        cycle(1'b0, 1'b1, 0);
        #1;
        chk("clr_wrap_pulse", int'(wrap_pulse), 1);
        chk("clr_wrap_count", int'(wrap_count), 0);
        chk("clr_err_sticky", int'(err_sticky), 0);
        chk("clr_err_count", int'(err_count), 0);

        feed(1); feed(2); feed(3); feed(3); feed(4);
        #1;
        chk("hold_err_count", int'(err_count), HOLD ? 0 : 1);
        chk("hold_lock", int'(lock), HOLD ? 1 : 0);
        feed(5);
        #1;
        chk("hold_relock", int'(lock), 1);

        cycle(1'b1, 1'b1, 3);
        #1;
        chk("midrst_lock", int'(lock), 0);
        chk("midrst_err_count", int'(err_count), 0);
        chk("midrst_err_sticky", int'(err_sticky), 0);
        chk("midrst_err_pulse", int'(err_pulse), 0);
        feed(4);
        #1;
        chk("midrst_idle_no_lock", int'(lock), 0);

        u = 4;
        for (int i = 0; i < 3000; i++) begin
            p  = $urandom_range(0, 99);
            rr = (p < 1);
            p  = $urandom_range(0, 99);
            cc = (p < 4);
            g  = $urandom_range(0, 99);
            if (g < 6) begin
                u = $urandom_range(0, 7);
            end else if (g >= 14) begin
                u = (u >= MOD) ? 0 : (u + 1) % MOD;
            end
            cycle(rr, cc, u);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
